// File: rtl/mips_mc_core.sv
// Multicycle MIPS32 core (lw/sw/R-type/addi/beq/bne/j) with a unified req/ready memory port and a sticky trap.
// Latency: lw 5, sw 4, R/addi 4, beq/bne/j 3 cycles with zero-wait memory; each memory wait cycle adds one.
// Backpressure: mem_req/mem_we/mem_adr/mem_wd are held stable until mem_ready; the core stalls in place meanwhile.
module mips_mc_core #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          NREGS       = 32,
  parameter bit          TRAP_ON_OVF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  input  logic        mem_ready,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] pc_dbg
);

  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [1:0] CAUSE_OVF = 2'd1;
  localparam logic [1:0] CAUSE_ILL = 2'd2;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP
  } stateT;

  stateT       state;
  stateT       nextState;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] regA;
  logic [31:0] regB;
  logic [31:0] mdr;
  logic [31:0] aluOut;
  logic [31:0] regFile [NREGS];

  // Instruction fields; register indices keep only the low bits so they wrap modulo NREGS
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [RW-1:0] rsIdx;
  logic [RW-1:0] rtIdx;
  logic [RW-1:0] rdIdx;
  logic [31:0]   immExt;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  assign rsIdx  = ir[21 +: RW];
  assign rtIdx  = ir[16 +: RW];
  assign rdIdx  = ir[11 +: RW];
  assign immExt = {{16{ir[15]}}, ir[15:0]};

  // ALU and addi adder; signed overflow uses the effective second operand (negated for subtraction)
  logic [31:0] bEff;
  logic [31:0] sum;
  logic [31:0] aluRes;
  logic        functOk;
  logic        aluOvf;
  logic        ovfTrapR;
  logic [31:0] addiSum;
  logic        addiOvf;
  logic        branchTaken;

  // R-type result, legality and overflow, plus the addi sum and branch condition
  always_comb begin
    bEff     = ((funct == FN_SUB) || (funct == FN_SUBU)) ? (~regB + 32'd1) : regB;
    sum      = regA + bEff;
    aluRes   = sum;
    functOk  = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU: aluRes = sum;
      FN_AND:  aluRes = regA & regB;
      FN_OR:   aluRes = regA | regB;
      FN_SLT:  aluRes = {31'd0, ($signed(regA) < $signed(regB))};
      default: begin
        aluRes  = 32'd0;
        functOk = 1'b0;
      end
    endcase
    aluOvf      = (regA[31] == bEff[31]) && (sum[31] != regA[31]);
    ovfTrapR    = TRAP_ON_OVF && aluOvf && ((funct == FN_ADD) || (funct == FN_SUB));
    addiSum     = regA + immExt;
    addiOvf     = TRAP_ON_OVF && (regA[31] == immExt[31]) && (addiSum[31] != regA[31]);
    branchTaken = (opcode == OP_BNE) ? (regA != regB) : (regA == regB);
  end

  // Cause recorded when the FSM moves into TRAP this cycle
  logic [1:0] causeNext;

  // Next-state logic and memory-port outputs
  always_comb begin
    nextState = state;
    causeNext = 2'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = aluOut;
    mem_wd    = regB;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        mem_adr = pc;
        if (mem_ready) nextState = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   nextState = MEMADR;
          OP_RTYPE:       nextState = EXEC;
          OP_ADDI:        nextState = ADDIEX;
          OP_BEQ, OP_BNE: nextState = BRANCH;
          OP_J:           nextState = JUMP;
          default: begin
            nextState = TRAP;
            causeNext = CAUSE_ILL;
          end
        endcase
      end
      MEMADR: nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        mem_req = 1'b1;
        if (mem_ready) nextState = MEMWB;
      end
      MEMWB: nextState = FETCH;
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) nextState = FETCH;
      end
      EXEC: begin
        if (!functOk) begin
          nextState = TRAP;
          causeNext = CAUSE_ILL;
        end else if (ovfTrapR) begin
          nextState = TRAP;
          causeNext = CAUSE_OVF;
        end else begin
          nextState = ALUWB;
        end
      end
      ALUWB: nextState = FETCH;
      ADDIEX: begin
        if (addiOvf) begin
          nextState = TRAP;
          causeNext = CAUSE_OVF;
        end else begin
          nextState = ADDIWB;
        end
      end
      ADDIWB: nextState = FETCH;
      BRANCH: nextState = FETCH;
      JUMP:   nextState = FETCH;
      TRAP:   nextState = TRAP;
      default: nextState = FETCH;
    endcase
  end

  // State register; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // Datapath registers, register file and sticky trap; writes land only in the *WB states
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      ir         <= 32'd0;
      regA       <= 32'd0;
      regB       <= 32'd0;
      mdr        <= 32'd0;
      aluOut     <= 32'd0;
      trap       <= 1'b0;
      trap_cause <= 2'd0;
      for (int i = 0; i < NREGS; i++) regFile[i] <= 32'd0;
    end else begin
      if ((nextState == TRAP) && (state != TRAP)) begin
        trap       <= 1'b1;
        trap_cause <= causeNext;
      end
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir <= mem_rd;
            pc <= pc + 32'd4;
          end
        end
        DECODE: begin
          regA   <= regFile[rsIdx];
          regB   <= regFile[rtIdx];
          aluOut <= pc + {immExt[29:0], 2'b00};
        end
        MEMADR: aluOut <= regA + immExt;
        MEMRD: begin
          if (mem_ready) mdr <= mem_rd;
        end
        MEMWB: begin
          if (rtIdx != '0) regFile[rtIdx] <= mdr;
        end
        EXEC:   aluOut <= aluRes;
        ALUWB: begin
          if (rdIdx != '0) regFile[rdIdx] <= aluOut;
        end
        ADDIEX: aluOut <= addiSum;
        ADDIWB: begin
          if (rtIdx != '0) regFile[rtIdx] <= aluOut;
        end
        BRANCH: begin
          if (branchTaken) pc <= aluOut;
        end
        JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  assign pc_dbg = pc;

endmodule

// File: tb/tb_mips_mc_core.sv
module tb_mips_mc_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ready = 1'b0;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] pc_dbg;

  always #5 clk = ~clk;

  mips_mc_core #(.RESET_PC(32'h100), .NREGS(32), .TRAP_ON_OVF(1'b1)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_ready(mem_ready), .trap(trap),
    .trap_cause(trap_cause), .pc_dbg(pc_dbg)
  );

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] adr;
    logic [31:0] wd;
    int          cyc;
  } evT;

  evT          expQ[$];
  evT          monEv;
  logic [31:0] mem    [0:1023];
  logic [31:0] refMem [0:1023];
  logic [31:0] prog[$];
  assign mem_rd = mem[mem_adr[11:2]];

  int   checks = 0;
  int   errors = 0;
  bit   monEn = 1'b0;
  int   readyMode = 0;  // 0 never ready, 1 always, 2 random percentage, 3 fixed wait
  int   readyPct = 100;
  int   fixedWait = 0;
  int   reqCycles = 0;
  int   cnt = 0;
  int   prevCyc = 0;
  bit   havePrev = 1'b0;
  bit   prevWait = 1'b0;
  logic [31:0] prevAdr = 32'd0;
  logic        prevWe = 1'b0;
  bit   preloadOvf = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] iT(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rT(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] jT(logic [31:0] target);
    return {6'h02, target[27:2]};
  endfunction

  // Memory responder and scoreboard monitor, both sampling on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      mem_ready = 1'b0;
      reqCycles = 0;
    end else begin
      if (!mem_req) begin
        mem_ready = 1'b0;
        reqCycles = 0;
      end else begin
        case (readyMode)
          0:       mem_ready = 1'b0;
          1:       mem_ready = 1'b1;
          2:       mem_ready = ($urandom_range(1, 100) <= readyPct);
          default: mem_ready = (reqCycles >= fixedWait);
        endcase
        if (mem_ready) reqCycles = 0;
        else           reqCycles++;
      end
      if (monEn) begin
        if (mem_req && prevWait) begin
          chk("held mem_adr", mem_adr, prevAdr);
          chk("held mem_we", {31'd0, mem_we}, {31'd0, prevWe});
        end
        prevWait = mem_req && !mem_ready;
        prevAdr  = mem_adr;
        prevWe   = mem_we;
        if (!(mem_req && !mem_ready)) cnt++;
        if (mem_req && mem_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected access: adr %h we %0d, none expected", mem_adr, mem_we);
          end else begin
            monEv = expQ.pop_front();
            chk("access we", {31'd0, mem_we}, {31'd0, monEv.we});
            chk("access adr", mem_adr, monEv.adr);
            if (monEv.we) chk("store data", mem_wd, monEv.wd);
            if (monEv.fetch) begin
              if (havePrev) chk("instr cycles", cnt, prevCyc);
              havePrev = 1'b1;
              prevCyc  = monEv.cyc;
              cnt      = 0;
            end
          end
        end
      end
      if (mem_req && mem_ready && mem_we) mem[mem_adr[11:2]] = mem_wd;
    end
  end

  // Instruction-level reference: executes the program from refMem, queues expected accesses
  task automatic modelRun(output logic [31:0] fpc, output logic [1:0] fcause);
    logic [31:0] r [32];
    logic [31:0] pc, ins, a, b, res, adr, simm;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    bit          done, ov;
    int          cyc;
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    pc = 32'h100; fcause = 2'd0; done = 1'b0;
    for (int step = 0; step < 600 && !done; step++) begin
      ins = refMem[pc[11:2]];
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      simm = {{16{ins[15]}}, ins[15:0]};
      a = r[rs]; b = r[rt];
      cyc = (op == 6'h23) ? 5 : (op == 6'h2b || op == 6'h00 || op == 6'h08) ? 4 : 3;
      expQ.push_back('{fetch: 1'b1, we: 1'b0, adr: pc, wd: 32'd0, cyc: cyc});
      pc = pc + 32'd4;
      case (op)
        6'h00: begin
          ov = 1'b0;
          case (ins[5:0])
            6'h20: begin res = a + b; ov = (a[31] == b[31]) && (res[31] != a[31]); end
            6'h22: begin res = a - b; ov = (a[31] == (-b) >> 31) && (res[31] != a[31]); end
            6'h21: res = a + b;
            6'h23: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin done = 1'b1; fcause = 2'd2; end
          endcase
          if (!done && ov) begin done = 1'b1; fcause = 2'd1; end
          if (!done && rd != 5'd0) r[rd] = res;
        end
        6'h08: begin
          res = a + simm;
          if ((a[31] == simm[31]) && (res[31] != a[31])) begin done = 1'b1; fcause = 2'd1; end
          else if (rt != 5'd0) r[rt] = res;
        end
        6'h23: begin
          adr = a + simm;
          expQ.push_back('{fetch: 1'b0, we: 1'b0, adr: adr, wd: 32'd0, cyc: 0});
          if (rt != 5'd0) r[rt] = refMem[adr[11:2]];
        end
        6'h2b: begin
          adr = a + simm;
          expQ.push_back('{fetch: 1'b0, we: 1'b1, adr: adr, wd: b, cyc: 0});
          refMem[adr[11:2]] = b;
        end
        6'h04: if (a == b) pc = pc + (simm << 2);
        6'h05: if (a != b) pc = pc + (simm << 2);
        6'h02: pc = {pc[31:28], ins[25:0], 2'b00};
        default: begin done = 1'b1; fcause = 2'd2; end
      endcase
    end
    fpc = pc;
  endtask

  task automatic buildDirected(logic [31:0] last);
    prog.delete();
    prog.push_back(iT(6'h08, 0, 1, 16'd5));        // 100 addi $1,$0,5
    prog.push_back(iT(6'h08, 0, 2, 16'd7));        // 104 addi $2,$0,7
    prog.push_back(rT(1, 2, 3, 6'h20));            // 108 add $3,$1,$2
    prog.push_back(iT(6'h2b, 0, 3, 16'h40));       // 10C sw $3,0x40($0)
    prog.push_back(iT(6'h23, 0, 4, 16'h40));       // 110 lw $4,0x40($0)
    prog.push_back(iT(6'h04, 1, 2, 16'd1));        // 114 beq not taken
    prog.push_back(iT(6'h08, 5, 5, 16'd1));        // 118 addi $5,$5,1
    prog.push_back(iT(6'h05, 5, 2, 16'hFFFE));     // 11C bne back to 118
    prog.push_back(jT(32'h128));                   // 120 j 0x128
    prog.push_back(32'hFC00_0000);                 // 124 skipped
    prog.push_back(iT(6'h2b, 0, 4, 16'h44));       // 128 sw $4,0x44
    prog.push_back(iT(6'h23, 0, 8, 16'h80));       // 12C lw $8,0x80 (0x7FFFFFFF)
    prog.push_back(iT(6'h08, 0, 9, 16'd1));        // 130 addi $9,$0,1
    prog.push_back(rT(8, 9, 10, 6'h21));           // 134 addu $10,$8,$9
    prog.push_back(iT(6'h2b, 0, 10, 16'h48));      // 138 sw $10,0x48
    prog.push_back(iT(6'h08, 0, 0, 16'd5));        // 13C addi $0,$0,5
    prog.push_back(iT(6'h2b, 0, 0, 16'h4C));       // 140 sw $0,0x4C
    prog.push_back(iT(6'h2b, 0, 5, 16'h50));       // 144 sw $5,0x50
    prog.push_back(last);                          // 148
  endtask

  task automatic buildRandom(int len, logic [31:0] last);
    logic [31:0] pc;
    logic [4:0]  ra, rb, rd;
    logic [5:0]  fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h21, 6'h23};
    int          k;
    prog.delete();
    for (int i = 0; i < len; i++) begin
      pc = 32'h100 + 32'(4 * prog.size());
      ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      k = $urandom_range(0, 9);
      if (k <= 2)      prog.push_back(iT(6'h08, ra, rd, 16'($urandom_range(0, 65535))));
      else if (k <= 5) prog.push_back(rT(ra, rb, rd, fns[$urandom_range(0, 6)]));
      else if (k == 6) prog.push_back(iT(6'h23, 0, rd, 16'(4 * $urandom_range(0, 63))));
      else if (k == 7) prog.push_back(iT(6'h2b, 0, rb, 16'(4 * $urandom_range(0, 63))));
      else if (k == 8) prog.push_back(iT($urandom_range(0, 1) ? 6'h05 : 6'h04, ra, rb, 16'($urandom_range(0, 2))));
      else             prog.push_back(jT(pc + 32'd4 + 32'(4 * $urandom_range(0, 2))));
    end
    for (int r = 1; r < 8; r++) prog.push_back(iT(6'h2b, 0, 5'(r), 16'(32'hC0 + 4 * r)));
    prog.push_back(last);
  endtask

  task automatic runProg(string name, int mode, int pct, int fw);
    logic [31:0] expPc;
    logic [1:0]  expCause;
    reset = 1'b1;
    monEn = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = (i < 64) ? $urandom : 32'd0;
    if (preloadOvf) mem[32] = 32'h7FFF_FFFF;
    foreach (prog[i]) mem[64 + i] = prog[i];
    for (int i = 0; i < 1024; i++) refMem[i] = mem[i];
    expQ.delete();
    modelRun(expPc, expCause);
    readyMode = mode; readyPct = pct; fixedWait = fw;
    cnt = 0; havePrev = 1'b0; prevWait = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    monEn = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 4000 && !trap; i++) @(posedge clk);
    #1;
    chk({name, " trap"}, {31'd0, trap}, 32'd1);
    chk({name, " trap_cause"}, {30'd0, trap_cause}, {30'd0, expCause});
    chk({name, " final pc"}, pc_dbg, expPc);
    repeat (4) begin
      @(negedge clk);
      chk({name, " mem_req after trap"}, {31'd0, mem_req}, 32'd0);
    end
    chk({name, " pending accesses"}, 32'(expQ.size()), 32'd0);
    monEn = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    // Reset state and reset vector
    reset = 1'b1;
    readyMode = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset mem_req", {31'd0, mem_req}, 32'd1);
    chk("reset mem_adr", mem_adr, 32'h100);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset trap", {31'd0, trap}, 32'd0);
    chk("reset trap_cause", {30'd0, trap_cause}, 32'd0);
    chk("reset pc", pc_dbg, 32'h100);
    // Reset coinciding with a completing fetch must win
    @(posedge clk);
    #1;
    readyMode = 1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    readyMode = 0;
    @(negedge clk);
    chk("mid-fetch reset pc", pc_dbg, 32'h100);
    chk("mid-fetch reset adr", mem_adr, 32'h100);
    chk("mid-fetch reset req", {31'd0, mem_req}, 32'd1);

    preloadOvf = 1'b1;
    buildDirected(rT(8, 9, 3, 6'h20));
    runProg("dir ovf zero-wait", 1, 100, 0);
    buildDirected(32'hFC00_0000);
    runProg("dir illop wait3", 3, 100, 3);
    buildDirected(rT(1, 2, 3, 6'h3f));
    runProg("dir badfunct random", 2, 40, 0);
    buildDirected(iT(6'h22, 8, 9, 16'd0));
    runProg("dir sub-opcode", 2, 70, 0);
    preloadOvf = 1'b0;
    for (int p = 0; p < 6; p++) begin
      buildRandom(24, (p % 2) ? 32'hFC00_0000 : rT(1, 1, 1, 6'h3f));
      runProg($sformatf("rand%0d", p), (p < 2) ? 1 : 2, $urandom_range(30, 100), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
